// File: rtl/cmd_link_pkg.sv
// Shared definitions for the analyzer command byte link (encoder and decoder side).
package cmd_link_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] CLRALL     = 8'hFF;
  localparam logic [3:0] SETTRIG    = 4'hE;
  localparam logic [3:0] INITTRIG   = 4'hD;
  localparam logic [3:0] TRIGEN     = 4'hC;
  localparam logic [3:0] TRIGDIS    = 4'hB;
  localparam logic [3:0] TRIGTIME   = 4'hA;
  localparam logic [3:0] SOFTRELOAD = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ORDER,
    ST_DATA,
    ST_GAP
  } enc_state_t;

  // A sync byte inside a frame would make the decoder resynchronise mid-frame.
  function automatic logic has_sync(input logic [7:0] order, input logic [7:0] data);
    return (order == SYNC_BYTE) || (data == SYNC_BYTE);
  endfunction

endpackage

// File: rtl/cmd_pair_fifo.sv
// Synchronous FIFO of 16-bit {order, data} command pairs with full/empty/count.
module cmd_pair_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          CLR,
  input  logic                          push,
  input  logic [15:0]                   wdata,
  input  logic                          pop,
  output logic [15:0]                   rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cmd_frame_encoder.sv
// Command link transmitter: frames buffered (order, data) pairs as order, data, A5 gap.
// Optional build macro CMD_A5_CHECK_EN drops pairs containing the sync byte and pulses cmd_err.
module cmd_frame_encoder
  import cmd_link_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD       = 1,
  parameter int MIN_GAP    = 1
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [7:0] cmd_order,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] DataOut,
  output logic       busy,
  output logic       frame_done,
  output logic       cmd_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0]  HOLD_INIT = 8'(HOLD - 1);
  localparam logic [15:0] GAP_INIT  = 16'(MIN_GAP * HOLD - 1);

  enc_state_t    state, state_n;
  logic [7:0]    dout_n;
  logic [7:0]    data_q, data_n;
  logic [7:0]    hold_cnt, hold_n;
  logic [15:0]   gap_cnt, gap_n;
  logic          push, pop, full, empty, accept;
  logic [15:0]   head;
  logic [CW-1:0] count;

  assign cmd_ready = ~full;
  assign accept    = cmd_valid & cmd_ready;

`ifdef CMD_A5_CHECK_EN
  logic reject;
  assign reject = accept & has_sync(cmd_order, cmd_data);
  assign push   = accept & ~reject;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) cmd_err <= 1'b0;
    else      cmd_err <= reject;
  end
`else
  assign push    = accept;
  assign cmd_err = 1'b0;
`endif

  cmd_pair_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK   (CLK),
    .CLR   (CLR),
    .push  (push),
    .wdata ({cmd_order, cmd_data}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign busy       = (count != '0) || (state != ST_IDLE);
  assign frame_done = (state == ST_GAP) && (gap_cnt == '0);

  always_comb begin
    state_n = state;
    dout_n  = DataOut;
    data_n  = data_q;
    hold_n  = hold_cnt;
    gap_n   = gap_cnt;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          dout_n  = head[15:8];
          data_n  = head[7:0];
          hold_n  = HOLD_INIT;
          state_n = ST_ORDER;
        end
      end
      ST_ORDER: begin
        if (hold_cnt == '0) begin
          dout_n  = data_q;
          hold_n  = HOLD_INIT;
          state_n = ST_DATA;
        end else begin
          hold_n = hold_cnt - 8'd1;
        end
      end
      ST_DATA: begin
        if (hold_cnt == '0) begin
          dout_n  = SYNC_BYTE;
          gap_n   = GAP_INIT;
          state_n = ST_GAP;
        end else begin
          hold_n = hold_cnt - 8'd1;
        end
      end
      ST_GAP: begin
        // Next frame follows the gap back-to-back when one is queued.
        if (gap_cnt == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            dout_n  = head[15:8];
            data_n  = head[7:0];
            hold_n  = HOLD_INIT;
            state_n = ST_ORDER;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          gap_n = gap_cnt - 16'd1;
        end
      end
      default: begin
        dout_n  = SYNC_BYTE;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state    <= ST_IDLE;
      DataOut  <= SYNC_BYTE;
      data_q   <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_n;
      DataOut  <= dout_n;
      data_q   <= data_n;
      hold_cnt <= hold_n;
      gap_cnt  <= gap_n;
    end
  end

endmodule

// File: tb/tb_cmd_frame_encoder.sv
// Self-checking bench for cmd_frame_encoder against a queue-based frame model.
// Works with or without CMD_A5_CHECK_EN defined.
module tb_cmd_frame_encoder;

  localparam int DEPTH   = 4;
  localparam int HOLD    = 3;
  localparam int MIN_GAP = 2;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic [7:0] cmd_order = '0;
  logic [7:0] cmd_data = '0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] DataOut;
  logic       busy;
  logic       frame_done;
  logic       cmd_err;

  int vectors = 0;
  int miscompares = 0;

  cmd_frame_encoder #(.FIFO_DEPTH(DEPTH), .HOLD(HOLD), .MIN_GAP(MIN_GAP)) dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .cmd_order  (cmd_order),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .DataOut    (DataOut),
    .busy       (busy),
    .frame_done (frame_done),
    .cmd_err    (cmd_err)
  );

  always #5 CLK = ~CLK;

  // kind: 0 order, 1 data, 2 gap, 3 idle
  typedef struct {
    logic [7:0] b;
    bit         done;
    int         kind;
  } slot_t;

  slot_t       sched[$];
  logic [15:0] pairq[$];
  logic [7:0]  m_dout = SYNC;
  bit          m_in_frame = 0;
  bit          m_done = 0;
  bit          m_err = 0;
  int          m_kind = 3;

  task automatic model_reset();
    sched.delete();
    pairq.delete();
    m_dout = SYNC; m_in_frame = 0; m_done = 0; m_err = 0; m_kind = 3;
  endtask

  task automatic model_edge(input bit acc, input logic [7:0] o, input logic [7:0] d);
    slot_t s;
    logic [15:0] p;
    if (sched.size() == 0 && pairq.size() > 0) begin
      p = pairq.pop_front();
      for (int h = 0; h < HOLD; h++) sched.push_back('{p[15:8], 1'b0, 0});
      for (int h = 0; h < HOLD; h++) sched.push_back('{p[7:0], 1'b0, 1});
      for (int g = 0; g < MIN_GAP * HOLD; g++)
        sched.push_back('{SYNC, (g == MIN_GAP * HOLD - 1), 2});
    end
    if (sched.size() > 0) begin
      s = sched.pop_front();
      m_dout = s.b; m_done = s.done; m_kind = s.kind; m_in_frame = 1;
    end else begin
      m_dout = SYNC; m_done = 0; m_kind = 3; m_in_frame = 0;
    end
    m_err = 0;
    if (acc) begin
`ifdef CMD_A5_CHECK_EN
      if (o == SYNC || d == SYNC) m_err = 1;
      else pairq.push_back({o, d});
`else
      pairq.push_back({o, d});
`endif
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("dataout", {8'h00, DataOut}, {8'h00, m_dout});
    chk("busy", {15'd0, busy}, {15'd0, (m_in_frame || pairq.size() > 0)});
    chk("frame_done", {15'd0, frame_done}, {15'd0, m_done});
    chk("cmd_ready", {15'd0, cmd_ready}, {15'd0, (pairq.size() < DEPTH)});
    chk("cmd_err", {15'd0, cmd_err}, {15'd0, m_err});
  endtask

  // Called just after a negedge: drive, clock, update model, check at the next negedge.
  task automatic step(input bit v, input logic [7:0] o, input logic [7:0] d);
    bit acc;
    cmd_valid = v; cmd_order = o; cmd_data = d;
    acc = v && (pairq.size() < DEPTH);
    @(posedge CLK);
    model_edge(acc, o, d);
    @(negedge CLK);
    cmd_valid = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    CLR = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(negedge CLK);
    CLR = 1'b1;
    check_all();
  endtask

  initial begin
    logic [7:0] o, d;
    bit         v, found;

    do_reset();
    idle(10);

    step(1'b1, 8'hE3, 8'h05);
    idle(15);

    step(1'b1, 8'hC0, 8'h00);
    step(1'b1, 8'hB0, 8'h00);
    step(1'b1, 8'hA0, 8'h7F);
    step(1'b1, 8'hD1, 8'h22);
    step(1'b1, 8'h9F, 8'h33);
    step(1'b1, 8'hE7, 8'h44);
    idle(80);

    step(1'b1, 8'h90, 8'hA5);
    idle(15);
    step(1'b1, 8'hFF, 8'h12);
    idle(15);

    for (int i = 0; i < 800; i++) begin
      v = ($urandom_range(0, 2) == 0);
      o = 8'($urandom);
      d = 8'($urandom);
      if ($urandom_range(0, 7) == 0) o = SYNC;
      if ($urandom_range(0, 7) == 0) d = SYNC;
      step(v, o, d);
    end
    idle(80);

    step(1'b1, 8'hC1, 8'h11);
    step(1'b1, 8'hC2, 8'h22);
    step(1'b1, 8'hC3, 8'h33);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_kind == 1) found = 1;
      else idle(1);
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $error("FAIL reach_data: observed not-reached expected data byte within 40 cycles");
    end
    chk("pre_reset_data", {8'h00, DataOut}, 16'h0011);
    CLR = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge CLK);
    CLR = 1'b1;
    check_all();
    idle(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
